// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: tear-free position handshake, frame-step divider,
// sprite ROM addressing and 2-cycle pixel pipeline. Define SPRITE_MIRROR_EN for horizontal mirroring.
module sprite_anim_ctrl #(
  parameter int SPR_W      = 110,
  parameter int SPR_H      = 86,
  parameter int FRAMES     = 4,
  parameter int FRAME_DIV  = 8,
  parameter int ADDR_W     = 16,
  parameter int TRANSP_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_load,
  output logic              pos_ack,
`ifdef SPRITE_MIRROR_EN
  input  logic              mirror,
`endif
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pixel_idx,
  output logic              pixel_valid,
  output logic [1:0]        frame_idx
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SPR_W * SPR_H);

  logic [9:0]        act_x, act_y;
  logic [DIV_W-1:0]  div_cnt;
  logic              in_box_d1, in_box_d2;
  logic              frame_start;
  logic              in_box;
  logic [9:0]        dx, dy, col;
  logic [10:0]       x_ext, y_ext, x_end, y_end;
  logic [ADDR_W-1:0] addr_next;

`ifdef SPRITE_MIRROR_EN
  logic act_mirror;
`endif

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd480);

  // 11-bit compares so a box hanging past the screen edge clips instead of wrapping.
  assign x_ext = {1'b0, DrawX};
  assign y_ext = {1'b0, DrawY};
  assign x_end = {1'b0, act_x} + 11'(SPR_W);
  assign y_end = {1'b0, act_y} + 11'(SPR_H);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_box    = 1'b0;
    dx        = DrawX - act_x;
    dy        = DrawY - act_y;
    col       = dx;
    addr_next = '0;
    in_box = blank
          && (x_ext >= {1'b0, act_x}) && (x_ext < x_end)
          && (y_ext >= {1'b0, act_y}) && (y_ext < y_end);
`ifdef SPRITE_MIRROR_EN
    if (act_mirror) col = 10'(SPR_W - 1) - dx;
`endif
    addr_next = ADDR_W'(frame_idx) * FRAME_WORDS
              + ADDR_W'(dy) * ADDR_W'(SPR_W)
              + ADDR_W'(col);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      act_x       <= '0;
      act_y       <= '0;
      div_cnt     <= '0;
      frame_idx   <= '0;
      pos_ack     <= 1'b0;
      rom_address <= '0;
      in_box_d1   <= 1'b0;
      in_box_d2   <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      act_mirror  <= 1'b0;
`endif
    end else begin
      pos_ack <= 1'b0;
      if (frame_start) begin
        if (pos_load) begin
          act_x   <= pos_x;
          act_y   <= pos_y;
          pos_ack <= 1'b1;
`ifdef SPRITE_MIRROR_EN
          act_mirror <= mirror;
`endif
        end
        if (anim_en) begin
          if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
            div_cnt   <= '0;
            frame_idx <= (frame_idx == 2'(FRAMES - 1)) ? 2'd0 : frame_idx + 2'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      end
      rom_address <= in_box ? addr_next : '0;
      in_box_d1   <= in_box;
      in_box_d2   <= in_box_d1;
    end
  end

  // NOTE: pixel outputs are gated combinationally by the reset-cleared flag, keeping
  // latency at 2 cycles while reset still forces them to 0 immediately.
  assign pixel_idx   = in_box_d2 ? rom_q : 4'd0;
  assign pixel_valid = in_box_d2 && (rom_q != 4'(TRANSP_IDX));

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl: arithmetic reference model checked every cycle,
// plus directed hand-computed expectations. ROM content is addr mod 16.
module tb_sprite_anim_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, pos_load, anim_en;
  logic        pos_ack;
  logic [15:0] rom_address;
  logic [3:0]  rom_q = 4'd0;
  logic [3:0]  pixel_idx;
  logic        pixel_valid;
  logic [1:0]  frame_idx;
`ifdef SPRITE_MIRROR_EN
  logic        mirror;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  sprite_anim_ctrl dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_load   (pos_load),
    .pos_ack    (pos_ack),
`ifdef SPRITE_MIRROR_EN
    .mirror     (mirror),
`endif
    .anim_en    (anim_en),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .pixel_idx  (pixel_idx),
    .pixel_valid(pixel_valid),
    .frame_idx  (frame_idx)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous-read sprite ROM; each word holds its own address mod 16.
  always @(posedge vga_clk) rom_q <= rom_address[3:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sprite placement from plain integer arithmetic.
  int m_ax = 0, m_ay = 0, m_steps = 0, m_mir = 0;
  int e_addr = 0, e_ib1 = 0, e_ib2 = 0, e_rom = 0, e_ack = 0;

  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ax = 0; m_ay = 0; m_steps = 0; m_mir = 0;
      e_addr = 0; e_ib1 = 0; e_ib2 = 0; e_rom = 0; e_ack = 0;
    end else begin
      int x, y, ib, col, fs;
      x  = int'(DrawX);
      y  = int'(DrawY);
      fs = (x == 0 && y == 480) ? 1 : 0;
      ib = (blank && x >= m_ax && x < m_ax + 110 && y >= m_ay && y < m_ay + 86) ? 1 : 0;
      col = m_mir ? 109 - (x - m_ax) : x - m_ax;
      e_ib2 = e_ib1;
      e_rom = e_addr % 16;
      e_ib1 = ib;
      e_addr = ib ? ((m_steps / 8) % 4) * 9460 + (y - m_ay) * 110 + col : 0;
      e_ack = (fs && pos_load) ? 1 : 0;
      if (fs) begin
        if (pos_load) begin
          m_ax = int'(pos_x);
          m_ay = int'(pos_y);
`ifdef SPRITE_MIRROR_EN
          m_mir = int'(mirror);
`endif
        end
        if (anim_en) m_steps++;
      end
    end
  end

  always @(negedge vga_clk) begin
    if (cmp_en) begin
      check("m_rom_address", 32'(rom_address), e_addr);
      check("m_pixel_idx",   32'(pixel_idx),   e_ib2 ? e_rom : 0);
      check("m_pixel_valid", 32'(pixel_valid), (e_ib2 && e_rom != 0) ? 1 : 0);
      check("m_pos_ack",     32'(pos_ack),     e_ack);
      check("m_frame_idx",   32'(frame_idx),   (m_steps / 8) % 4);
    end
  end

  // Present one pixel for one clock; returns 1 time unit after the sampling edge.
  task automatic px(input int x, input int y, input bit b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic fs_line();
    px(0, 480, 1'b0);
    px(7, 7, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0;
    pos_x = '0; pos_y = '0; pos_load = 1'b0; anim_en = 1'b0;
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
    repeat (3) @(posedge vga_clk);
    #1;
    cmp_en = 1'b1;
    check("rst_rom_address", 32'(rom_address), 0);
    check("rst_pos_ack",     32'(pos_ack),     0);
    check("rst_frame_idx",   32'(frame_idx),   0);
    check("rst_pixel_valid", 32'(pixel_valid), 0);
    reset_n = 1'b1;

    // Mid-frame position request: held pending, acked once after frame start.
    px(10, 10, 1'b1);
    pos_x = 10'd100; pos_y = 10'd50; pos_load = 1'b1;
    repeat (4) begin
      px(20, 20, 1'b1);
      check("ack_pending", 32'(pos_ack), 0);
    end
    px(0, 480, 1'b0);
    check("ack_pulse", 32'(pos_ack), 1);
    pos_load = 1'b0;
    px(100, 50, 1'b1);
    check("ack_single", 32'(pos_ack), 0);
    check("addr_origin", 32'(rom_address), 0);
    px(101, 50, 1'b1);
    check("addr_next_col", 32'(rom_address), 1);
    px(209, 135, 1'b1);
    check("addr_corner", 32'(rom_address), 9459);
    px(210, 135, 1'b1);
    check("addr_right_out", 32'(rom_address), 0);
    check("pix_corner_idx", 32'(pixel_idx), 3);
    check("pix_corner_valid", 32'(pixel_valid), 1);
    px(0, 0, 1'b0);
    check("pix_right_out_valid", 32'(pixel_valid), 0);

    // Transparent vs opaque ROM data.
    px(100, 50, 1'b1);
    px(105, 50, 1'b1);
    check("transp_idx", 32'(pixel_idx), 0);
    check("transp_valid", 32'(pixel_valid), 0);
    px(0, 0, 1'b0);
    check("opaque_idx", 32'(pixel_idx), 5);
    check("opaque_valid", 32'(pixel_valid), 1);
    px(120, 60, 1'b0);
    check("blank_addr", 32'(rom_address), 0);

    // Animation divider and frame wrap.
    anim_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      fs_line();
      if (i == 7) check("frame_before_step", 32'(frame_idx), 0);
      if (i == 8) check("frame_first_step", 32'(frame_idx), 1);
    end
    check("frame_wrap", 32'(frame_idx), 0);
    repeat (8) fs_line();
    check("frame_after_40", 32'(frame_idx), 1);
    anim_en = 1'b0;
    repeat (8) fs_line();
    check("frame_hold", 32'(frame_idx), 1);

    // Position and frame step on the same frame start.
    anim_en = 1'b1;
    repeat (7) fs_line();
    pos_x = 10'd600; pos_y = 10'd400; pos_load = 1'b1;
    px(0, 480, 1'b0);
    check("joint_frame", 32'(frame_idx), 2);
    check("joint_ack", 32'(pos_ack), 1);
    pos_load = 1'b0; anim_en = 1'b0;
    px(600, 400, 1'b1);
    check("clip_origin_addr", 32'(rom_address), 18920);

    // Clipping at the right and bottom screen edges.
    for (int x = 0; x < 640; x++) begin
      px(x, 420, 1'b1);
      if (x == 639) check("clip_last_col_addr", 32'(rom_address), 21159);
      if (x == 69)  check("clip_nowrap_addr", 32'(rom_address), 0);
    end
    for (int x = 0; x < 70; x++) px(x, 0, 1'b1);
    px(0, 0, 1'b0);

    // Highest ROM address at the last frame.
    anim_en = 1'b1;
    repeat (7) fs_line();
    pos_x = 10'd100; pos_y = 10'd50; pos_load = 1'b1;
    px(0, 480, 1'b0);
    pos_load = 1'b0; anim_en = 1'b0;
    check("frame_last", 32'(frame_idx), 3);
    px(209, 135, 1'b1);
    check("addr_max", 32'(rom_address), 37839);

    // Asynchronous reset mid-line with a pending request.
    pos_x = 10'd300; pos_y = 10'd300; pos_load = 1'b1;
    px(209, 135, 1'b1);
    check("pre_rst_idx", 32'(pixel_idx), 15);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rom_address", 32'(rom_address), 0);
    check("async_pixel_idx",   32'(pixel_idx),   0);
    check("async_pixel_valid", 32'(pixel_valid), 0);
    check("async_frame_idx",   32'(frame_idx),   0);
    check("async_pos_ack",     32'(pos_ack),     0);
    pos_load = 1'b0;
    px(0, 0, 1'b0);
    px(0, 0, 1'b0);
    reset_n = 1'b1;
    px(0, 480, 1'b0);
    check("post_rst_no_ack", 32'(pos_ack), 0);
    px(0, 0, 1'b1);
    px(5, 1, 1'b1);
    check("post_rst_addr", 32'(rom_address), 115);
    check("post_rst_frame", 32'(frame_idx), 0);

`ifdef SPRITE_MIRROR_EN
    mirror = 1'b1;
    pos_x = 10'd100; pos_y = 10'd50; pos_load = 1'b1;
    px(0, 480, 1'b0);
    pos_load = 1'b0;
    px(100, 50, 1'b1);
    check("mirror_left_addr", 32'(rom_address), 109);
    px(209, 50, 1'b1);
    check("mirror_right_addr", 32'(rom_address), 0);
    px(101, 51, 1'b1);
    check("mirror_row1_addr", 32'(rom_address), 218);
`endif

    px(0, 0, 1'b0);
    px(0, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_anim_ctrl.md
SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

Interface
REQ-001 Parameters SHALL be: SPR_W 110 sprite width in pixels; SPR_H 86 sprite height; FRAMES 4 animation frames stored back-to-back in ROM; FRAME_DIV 8 video frames per animation step; ADDR_W 16 ROM address width; TRANSP_IDX 0 palette index treated as transparent.
REQ-002 Ports SHALL be:
- vga_clk  in  1  pixel clock, sole clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- pos_x  in  10  requested sprite left column.
- pos_y  in  10  requested sprite top row.
- pos_load  in  1  position update request; held with stable data until ack.
- pos_ack  out  1  one-cycle acknowledge; position applied.
- anim_en  in  1  1 = animation advances.
- rom_address  out  ADDR_W  registered address to sprite ROM (1-cycle synchronous read).
- rom_q  in  4  palette index returned by ROM.
- pixel_idx  out  4  palette index for current output pixel.
- pixel_valid  out  1  1 = sprite pixel opaque and shown.
- frame_idx  out  2  current animation frame.

Function
REQ-003 frame_start SHALL be a one-cycle internal pulse when DrawX==0 and DrawY==480 (first vertical-blank pixel).
REQ-004 Active position registers (act_x, act_y) SHALL change only on frame_start; no mid-frame tearing.
REQ-005 If pos_load==1 on frame_start, pos_x/pos_y SHALL be latched into act_x/act_y and pos_ack SHALL be 1 in the following cycle only; otherwise pos_ack stays 0.
REQ-006 pos_load rising between frame starts SHALL be held pending with no timeout; a requester dropping pos_load before ack SHALL cause no update.
REQ-007 In-box SHALL be: DrawX>=act_x, DrawX<act_x+SPR_W, DrawY>=act_y, DrawY<act_y+SPR_H, blank==1; comparisons 11 bits wide so boxes extending past column 639 or row 479 clip, not wrap.
REQ-008 rom_address SHALL be registered at the edge after DrawX/DrawY are presented: frame_idx*SPR_W*SPR_H + (DrawY-act_y)*SPR_W + (DrawX-act_x); when not in-box it SHALL hold 0.
REQ-009 In-box flag SHALL be delayed two cycles to align with rom_q; pixel_idx SHALL equal rom_q when the delayed flag is 1, else 0.
REQ-010 pixel_valid SHALL equal delayed in-box AND rom_q != TRANSP_IDX; total latency DrawX/DrawY to pixel_idx/pixel_valid SHALL be 2 cycles.
REQ-011 Divider div_cnt (0..FRAME_DIV-1) SHALL increment on frame_start when anim_en==1; on wrap to 0, frame_idx SHALL increment modulo FRAMES.
REQ-012 anim_en==0 SHALL hold div_cnt and frame_idx unchanged.
REQ-013 frame_idx and position SHALL update on the same frame_start edge when both occur; the next visible frame uses both new values.
REQ-014 Highest address SHALL be FRAMES*SPR_W*SPR_H-1 (37839 at defaults) and SHALL fit ADDR_W.

Reset
REQ-015 reset_n low SHALL asynchronously clear act_x, act_y, div_cnt, frame_idx, delay pipeline, rom_address, pixel_idx, pixel_valid and pos_ack to 0.
REQ-016 Reset mid-frame SHALL drop any pending request without ack; the first frame after release draws at (0,0) frame 0.

Configuration
REQ-017 With macro SPRITE_MIRROR_EN defined, input port mirror (1 bit) SHALL exist, be latched with the position under the REQ-005 handshake, and, when latched 1, column term SHALL be SPR_W-1-(DrawX-act_x).
REQ-018 Without SPRITE_MIRROR_EN, the mirror port SHALL be absent and column term always DrawX-act_x.

Verification
REQ-019 Reset, pos_load=1 with (100,50) mid-frame -> pos_ack pulses once, one cycle after next frame_start; after that frame_start, DrawX=100,DrawY=50 gives rom_address=0 one cycle later.
REQ-020 act=(100,50), frame_idx=0, DrawX=209,DrawY=135 -> rom_address=9459; DrawX=210 -> rom_address=0, pixel_valid=0 two cycles later.
REQ-021 act=(600,400), scan row 420 -> pixel_valid only for DrawX 600..639; no wrap hits at DrawX 0..69 or row 0.
REQ-022 anim_en=1 for 8 frame_starts -> frame_idx 0->1; 32 frame_starts -> returns to 0; anim_en=0 for 8 more -> frame_idx unchanged.
REQ-023 rom_q=0 in-box -> pixel_valid=0, pixel_idx=0; rom_q=5 in-box -> pixel_valid=1, pixel_idx=5, two cycles after DrawX presented.
REQ-024 SPRITE_MIRROR_EN, mirror=1, act=(100,50), DrawX=100,DrawY=50 -> rom_address=109; reset asserted mid-line -> all outputs 0 same cycle.
